// File: rtl/imem_boot_loader.sv
// Boot loader and run supervisor: streams a length-prefixed program image into
// instruction memory, releases the core, then watches for halt or timeout.
module imem_boot_loader #(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                  clock_proc,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_rst,
    input  logic                  halt,
    output logic [31:0]           cycle_count,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic                  error,
    output logic [2:0]            dbg_state
);

    // Byte handshake: a byte moves only on a cycle where in_valid && in_ready;
    // the source must hold in_data stable until then.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR_LO  = 3'd1,
        S_HDR_HI  = 3'd2,
        S_LOAD    = 3'd3,
        S_RUN     = 3'd4,
        S_HALTED  = 3'd5,
        S_TIMEOUT = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    localparam logic [31:0] CAPACITY     = 32'd1 << ADDR_WIDTH;
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    state_t                state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic [31:0]           cycle_count_q, cycle_count_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  timeout_q, timeout_d;
    logic                  error_q, error_d;
    logic [15:0]           len_q, len_d;
    logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           asm_q, asm_d;

    logic        accept;
    logic [15:0] hdr_len;
    logic        last_word;
    logic        timeout_hit;

    assign accept      = in_valid && in_ready_q;
    assign hdr_len     = {in_data, len_q[7:0]};
    assign last_word   = (32'(word_idx_q) == (32'(len_q) - 32'd1));
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_count_q == TIMEOUT_LAST);

    always_comb begin
        state_d       = state_q;
        in_ready_d    = in_ready_q;
        imem_we_d     = 1'b0;
        imem_addr_d   = imem_addr_q;
        imem_wdata_d  = imem_wdata_q;
        cpu_rst_d     = cpu_rst_q;
        cycle_count_d = cycle_count_q;
        busy_d        = busy_q;
        done_d        = done_q;
        timeout_d     = timeout_q;
        error_d       = error_q;
        len_d         = len_q;
        word_idx_d    = word_idx_q;
        byte_cnt_d    = byte_cnt_q;
        asm_d         = asm_q;

        case (state_q)
            S_IDLE, S_HALTED, S_TIMEOUT, S_ERROR: begin
                if (start) begin
                    state_d       = S_HDR_LO;
                    in_ready_d    = 1'b1;
                    cpu_rst_d     = 1'b1;
                    busy_d        = 1'b1;
                    done_d        = 1'b0;
                    timeout_d     = 1'b0;
                    error_d       = 1'b0;
                    cycle_count_d = 32'd0;
                    len_d         = 16'd0;
                    word_idx_d    = '0;
                    byte_cnt_d    = 2'd0;
                end
            end

            S_HDR_LO: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                    state_d    = S_HDR_HI;
                end
            end

            S_HDR_HI: begin
                if (accept) begin
                    len_d = hdr_len;
                    if (hdr_len == 16'd0) begin
                        state_d    = S_RUN;
                        in_ready_d = 1'b0;
                        cpu_rst_d  = 1'b0;
                    end else if (32'(hdr_len) > CAPACITY) begin
                        state_d    = S_ERROR;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b0;
                        error_d    = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                // in_ready low here means this cycle carries the final write strobe.
                if (!in_ready_q) begin
                    state_d   = S_RUN;
                    cpu_rst_d = 1'b0;
                end else if (accept) begin
                    case (byte_cnt_q)
                        2'd0: asm_d[7:0]   = in_data;
                        2'd1: asm_d[15:8]  = in_data;
                        2'd2: asm_d[23:16] = in_data;
                        default: begin
                            imem_we_d    = 1'b1;
                            imem_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
                            imem_wdata_d = {in_data, asm_q};
                            word_idx_d   = word_idx_q + 1'b1;
                            if (last_word) begin
                                in_ready_d = 1'b0;
                            end
                        end
                    endcase
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
            end

            S_RUN: begin
                if (halt) begin
                    state_d   = S_HALTED;
                    done_d    = 1'b1;
                    cpu_rst_d = 1'b1;
                    busy_d    = 1'b0;
                end else if (timeout_hit) begin
                    state_d   = S_TIMEOUT;
                    timeout_d = 1'b1;
                    cpu_rst_d = 1'b1;
                    busy_d    = 1'b0;
                end else if (cycle_count_q != 32'hFFFF_FFFF) begin
                    cycle_count_d = cycle_count_q + 32'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_proc) begin
        if (rst) begin
            state_q       <= S_IDLE;
            in_ready_q    <= 1'b0;
            imem_we_q     <= 1'b0;
            imem_addr_q   <= '0;
            imem_wdata_q  <= 32'd0;
            cpu_rst_q     <= 1'b1;
            cycle_count_q <= 32'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            error_q       <= 1'b0;
            len_q         <= 16'd0;
            word_idx_q    <= '0;
            byte_cnt_q    <= 2'd0;
            asm_q         <= 24'd0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            imem_we_q     <= imem_we_d;
            imem_addr_q   <= imem_addr_d;
            imem_wdata_q  <= imem_wdata_d;
            cpu_rst_q     <= cpu_rst_d;
            cycle_count_q <= cycle_count_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
            error_q       <= error_d;
            len_q         <= len_d;
            word_idx_q    <= word_idx_d;
            byte_cnt_q    <= byte_cnt_d;
            asm_q         <= asm_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign imem_we     = imem_we_q;
    assign imem_addr   = imem_addr_q;
    assign imem_wdata  = imem_wdata_q;
    assign cpu_rst     = cpu_rst_q;
    assign cycle_count = cycle_count_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign error       = error_q;
    assign dbg_state   = state_q;

endmodule
